// File: rtl/regfile_fifo_ctrl_pkg.sv
// Shared constants for the register-file FIFO controller: depth, pointer and
// count widths, and the selectable almost-full thresholds.
package regfile_fifo_ctrl_pkg;

    localparam int unsigned FIFO_DEPTH = 32;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned COUNT_W    = 6;

    localparam logic [COUNT_W-1:0] AF_TH0 = 6'd28;
    localparam logic [COUNT_W-1:0] AF_TH1 = 6'd24;
    localparam logic [COUNT_W-1:0] AF_TH2 = 6'd16;
    localparam logic [COUNT_W-1:0] AF_TH3 = 6'd8;

    // Map the two threshold-select configuration bits to an occupancy level
    function automatic logic [COUNT_W-1:0] af_threshold(input logic [1:0] sel);
        case (sel)
            2'b00:   return AF_TH0;
            2'b01:   return AF_TH1;
            2'b10:   return AF_TH2;
            default: return AF_TH3;
        endcase
    endfunction

endpackage

// File: rtl/regfile_fifo_ctrl_fifo_ptr_counter.sv
// Wrapping pointer counter with increment enable and synchronous active-low
// reset; used for both the write and the read pointer of the FIFO.
module fifo_ptr_counter #(
    parameter int unsigned W = 5
) (
    input  logic         UserCLK,
    input  logic         UserRSTn,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Advance by one per accepted request; natural overflow wraps to zero
    always_ff @(posedge UserCLK) begin
        if (!UserRSTn) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_fifo_ctrl.sv
// Pointer/flag controller turning the 32x4 register file into a
// first-word-fall-through FIFO. Read data comes from the register file's
// combinational port A addressed by A_ADR.
// Optional macro REGFILE_FIFO_ERR_EN adds sticky overflow/underflow flags err[1:0].
module regfile_fifo_ctrl #(
    parameter int unsigned ADDR_W       = regfile_fifo_ctrl_pkg::ADDR_W,
    parameter int unsigned NoConfigBits = 3
) (
    input  logic                    UserCLK,
    input  logic                    UserRSTn,
    input  logic                    push,
    input  logic                    pop,
    output logic [ADDR_W-1:0]       W_ADR,
    output logic                    W_en,
    output logic [ADDR_W-1:0]       A_ADR,
    output logic                    push_ok,
    output logic                    pop_ok,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    input  logic [NoConfigBits-1:0] ConfigBits
`ifdef REGFILE_FIFO_ERR_EN
   ,output logic [1:0]              err
`endif
);

    import regfile_fifo_ctrl_pkg::*;

    localparam int unsigned CW = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     af_th;
    logic              en;

    // Reset takes priority over requests, so acceptance is also masked while
    // UserRSTn is low; this keeps W_en quiet during the reset cycle.
    assign en      = ConfigBits[0] & UserRSTn;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    assign pop_ok  = en & pop & ~empty;
    assign push_ok = en & push & (~full | pop_ok);
    assign W_en    = push_ok;
    assign W_ADR   = wr_ptr;
    assign A_ADR   = rd_ptr;
    assign af_th   = CW'(af_threshold(ConfigBits[2:1]));
    assign almost_full = (count >= af_th);

    fifo_ptr_counter #(.W(ADDR_W)) u_wr_ptr (
        .UserCLK  (UserCLK),
        .UserRSTn (UserRSTn),
        .inc      (push_ok),
        .ptr      (wr_ptr)
    );

    fifo_ptr_counter #(.W(ADDR_W)) u_rd_ptr (
        .UserCLK  (UserCLK),
        .UserRSTn (UserRSTn),
        .inc      (pop_ok),
        .ptr      (rd_ptr)
    );

    // Occupancy: +1 on push only, -1 on pop only, unchanged on both or neither
    always_ff @(posedge UserCLK) begin
        if (!UserRSTn) begin
            count <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef REGFILE_FIFO_ERR_EN
    // Sticky error capture: bit0 rejected push, bit1 pop while empty
    always_ff @(posedge UserCLK) begin
        if (!UserRSTn) begin
            err <= '0;
        end else begin
            if (push & en & ~push_ok) err[0] <= 1'b1;
            if (pop & en & empty)     err[1] <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/regfile_fifo_ctrl.md
Name: regfile_fifo_ctrl

Overview:
- FIFO pointer/flag controller that sits directly upstream of the 32x4 register-file BEL and turns it into a 32-entry, 4-bit, first-word-fall-through FIFO.
- Drives the register file's write address, write enable and port-A read address.
- Produces full/empty/almost-full status and push/pop acceptance toward the switch matrix.
- Read data comes straight from the register file's port A, which must be configured combinational (unregistered).

Parameters:
- ADDR_W, 5, pointer width; depth = 2**ADDR_W = 32.
- NoConfigBits, 3, configuration bit count (bit 0: enable; bits 2:1: almost-full threshold select).

Ports:
- UserCLK  input  1  fabric user clock, shared with the register file.
- UserRSTn  input  1  synchronous reset, active-low. One clock; reset is synchronous and active-low.
- push  input  1  write request; data is presented on the register file D inputs in the same cycle.
- pop  input  1  read request; consumes the word currently visible on the register file AD port.
- W_ADR  output  ADDR_W  write address to the register file (write pointer).
- W_en  output  1  register file write enable; equals push_ok.
- A_ADR  output  ADDR_W  port-A read address (read pointer).
- push_ok  output  1  push accepted this cycle (combinational).
- pop_ok  output  1  pop accepted this cycle (combinational).
- full  output  1  count == 32.
- empty  output  1  count == 0.
- almost_full  output  1  count >= selected threshold.
- ConfigBits  input  NoConfigBits  configuration bits.

Behaviour:
- State registers: wr_ptr[4:0], rd_ptr[4:0], count[5:0] (range 0..32).
- Reset (UserRSTn=0 at a rising edge of UserCLK): wr_ptr=0, rd_ptr=0, count=0.
  - Resulting outputs: W_ADR=0, A_ADR=0, empty=1, full=0, almost_full=0.
  - Reset overrides push/pop in that cycle. A mid-stream reset discards contents logically; register file memory is not cleared.
- ConfigBits[0]=0 (disabled): push_ok=pop_ok=W_en=0 and pointers hold. Flags still reflect count.
- Acceptance rules (combinational):
  - pop_ok = en & pop & !empty.
  - push_ok = en & push & (!full | pop_ok).
- Push into a full FIFO is accepted only when a pop is accepted in the same cycle. The slot being read this cycle is overwritten at the edge, which is safe because the read is combinational.
- Pop from an empty FIFO is ignored, even with a simultaneous push. Pushed data becomes visible on AD one cycle later.
- On each edge:
  - push_ok: wr_ptr <= wr_ptr+1, wrapping 31->0 (modulo 32).
  - pop_ok: rd_ptr <= rd_ptr+1, wrapping 31->0.
  - count <= count + push_ok - pop_ok; both accepted leaves count unchanged.
- Outputs: W_ADR = wr_ptr, A_ADR = rd_ptr, W_en = push_ok.
- Read latency: data written at edge N is readable (empty=0, AD valid) in the cycle after edge N.
- almost_full threshold from ConfigBits[2:1]: 00->28, 01->24, 10->16, 11->8.
- Flags are combinational from the count register, so they are glitch-free relative to the clock.

Optional Feature:
- Macro: REGFILE_FIFO_ERR_EN.
- Defined: adds output err[1:0] (bit0 overflow, bit1 underflow).
  - Overflow is set on push & en & !push_ok; underflow is set on pop & en & empty.
  - Both bits are sticky until reset.
- Undefined: port and logic are absent; rejected requests are silently dropped.

Decomposition:
- Shared package: FIFO_DEPTH=32, ADDR_W=5, COUNT_W=6, and the threshold constants AF_TH0..AF_TH3 = 28/24/16/8.
- One natural sub-module, fifo_ptr_counter: a wrapping ADDR_W-bit counter with increment enable and synchronous reset, instantiated twice (write and read).
- Flag and acceptance logic stays in the top module.

Test Plan:
- Reset: assert UserRSTn=0 with push=1 -> after the edge, W_ADR=0, A_ADR=0, empty=1, W_en=0 in the reset cycle.
- Fill: 32 pushes with data 0..15 repeating, ConfigBits=3'b001 -> almost_full rises after the 28th push, full=1 after the 32nd; a 33rd push gives push_ok=0 and W_ADR stays 0 (wrapped).
- Drain: 32 pops -> AD sequence matches push order, A_ADR wraps 31->0, empty=1 after the last; a further pop gives pop_ok=0 and A_ADR is unchanged.
- Simultaneous push and pop at full: count stays 32, the write lands at the slot just popped, and the next AD value is the oldest remaining word.
- Simultaneous push and pop at empty: pop_ok=0, push_ok=1, count=1, empty=0 next cycle.
- Disabled (ConfigBits[0]=0) with push/pop toggling: W_en=0 and pointers frozen.
- With REGFILE_FIFO_ERR_EN defined: a push at full sets err=01 and holds it until reset.
